mem_chain_initiator: RTL and testbench

Lane-level initiator at the head of the vector-cache SRAM group chain. It accepts requests from the arbiter, launches read commands, or write commands with write data, into one chain lane, and reserves response-buffer credit for every read. It captures read data returning from the tail of the chain at a fixed latency and presents it, with the originating payload, on a valid/ready response port. The design instantiates one per lane (8 lanes), feeding the `read_cmd_*`/`write_cmd_*`/`wr_data_*` inputs of the first `mem_block` and consuming the `rd_data_out*` of the last.

---
 rtl/mem_chain_initiator.sv | 195 +++++++++++++++++++
 tb/tb_mem_chain_initiator.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_chain_initiator.sv
// Chain-lane initiator: launches read/write commands into the SRAM group chain and collects
// fixed-latency read returns into a credit-managed FWFT response FIFO.
// Optional build macro: MEM_CHAIN_INIT_CHECK_EN (return-slot checking, error flags, overflow check).
package mem_chain_pkg;
    typedef struct packed {
        logic [3:0]  src_id;
        logic [15:0] addr;
        logic [7:0]  tag;
    } arb_out_req_t;
endpackage

module mem_chain_initiator
    import mem_chain_pkg::*;
#(
    parameter int RD_LAT      = 8,
    parameter int WR_DATA_OFS = 2,
    parameter int RSP_DEPTH   = 8
) (
    input  logic         clk_2g,
    input  logic         rst_n,
    // Handshakes: a transfer happens in a cycle where valid and ready are both high; valid
    // never depends combinationally on ready, and req_rdy depends only on internal state.
    input  logic         req_vld,
    output logic         req_rdy,
    input  logic         req_is_wr,
    input  arb_out_req_t req_pld,
    input  logic [31:0]  req_wdata,
    output logic         read_cmd_vld_out,
    output arb_out_req_t read_cmd_pld_out,
    output logic         write_cmd_vld_out,
    output arb_out_req_t write_cmd_pld_out,
    output logic         wr_data_out_vld,
    output logic [31:0]  wr_data_out,
    input  logic         rd_data_in_vld,
    input  logic [31:0]  rd_data_in,
    output logic         rsp_vld,
    input  logic         rsp_rdy,
    output logic [31:0]  rsp_data,
    output arb_out_req_t rsp_pld,
    output logic [4:0]   rd_outstanding,
    output logic         err_lost,
    output logic         err_spurious
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;

    logic          acc_rd, acc_wr;
    logic [31:0]   wd_stage;
    logic [CW-1:0] fifo_count;
    logic [5:0]    credit_used;

    // Reserved credit covers reads still in the chain plus responses waiting to be popped.
    assign credit_used = 6'(rd_outstanding) + 6'(fifo_count);
    assign req_rdy     = credit_used < 6'(RSP_DEPTH);
    assign acc_rd      = req_vld && req_rdy && !req_is_wr;
    assign acc_wr      = req_vld && req_rdy && req_is_wr;

    always_ff @(posedge clk_2g or negedge rst_n) begin
        if (!rst_n) begin
            read_cmd_vld_out  <= 1'b0;
            read_cmd_pld_out  <= '0;
            write_cmd_vld_out <= 1'b0;
            write_cmd_pld_out <= '0;
            wd_stage          <= '0;
        end else begin
            read_cmd_vld_out  <= acc_rd;
            read_cmd_pld_out  <= acc_rd ? req_pld : '0;
            write_cmd_vld_out <= acc_wr;
            write_cmd_pld_out <= acc_wr ? req_pld : '0;
            wd_stage          <= acc_wr ? req_wdata : '0;
        end
    end

    generate
        if (WR_DATA_OFS == 0) begin : g_wd_direct
            assign wr_data_out_vld = write_cmd_vld_out;
            assign wr_data_out     = wd_stage;
        end else begin : g_wd_pipe
            logic        vld_pipe [WR_DATA_OFS];
            logic [31:0] dat_pipe [WR_DATA_OFS];
            always_ff @(posedge clk_2g or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < WR_DATA_OFS; i++) begin
                        vld_pipe[i] <= 1'b0;
                        dat_pipe[i] <= '0;
                    end
                end else begin
                    vld_pipe[0] <= write_cmd_vld_out;
                    dat_pipe[0] <= wd_stage;
                    for (int i = 1; i < WR_DATA_OFS; i++) begin
                        vld_pipe[i] <= vld_pipe[i-1];
                        dat_pipe[i] <= dat_pipe[i-1];
                    end
                end
            end
            assign wr_data_out_vld = vld_pipe[WR_DATA_OFS-1];
            assign wr_data_out     = dat_pipe[WR_DATA_OFS-1];
        end
    endgenerate

    // Slot pipe fed from the registered command: the tail holds the read launched RD_LAT cycles ago.
    logic         slot_vld [RD_LAT];
    arb_out_req_t slot_pld [RD_LAT];

    always_ff @(posedge clk_2g or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                slot_vld[i] <= 1'b0;
                slot_pld[i] <= '0;
            end
        end else begin
            slot_vld[0] <= read_cmd_vld_out;
            slot_pld[0] <= read_cmd_pld_out;
            for (int i = 1; i < RD_LAT; i++) begin
                slot_vld[i] <= slot_vld[i-1];
                slot_pld[i] <= slot_pld[i-1];
            end
        end
    end

    logic        push, pop, full;
    logic [31:0] push_data;

    assign push = slot_vld[RD_LAT-1];

`ifdef MEM_CHAIN_INIT_CHECK_EN
    assign push_data = rd_data_in_vld ? rd_data_in : 32'h0;

    always_ff @(posedge clk_2g or negedge rst_n) begin
        if (!rst_n) begin
            err_lost     <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            if (push && !rd_data_in_vld) err_lost <= 1'b1;
            if (!push && rd_data_in_vld) err_spurious <= 1'b1;
        end
    end
`else
    logic unused_rd_vld;
    assign unused_rd_vld = rd_data_in_vld;
    assign push_data     = rd_data_in;
    assign err_lost      = 1'b0;
    assign err_spurious  = 1'b0;
`endif

    logic [31:0]   fifo_data [RSP_DEPTH];
    arb_out_req_t  fifo_pld  [RSP_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    assign full     = fifo_count == CW'(RSP_DEPTH);
    assign rsp_vld  = fifo_count != '0;
    assign pop      = rsp_vld && rsp_rdy;
    assign rsp_data = rsp_vld ? fifo_data[rd_ptr] : '0;
    assign rsp_pld  = rsp_vld ? fifo_pld[rd_ptr] : '0;

    always_ff @(posedge clk_2g) begin
        if (push) begin
            fifo_data[wr_ptr] <= push_data;
            fifo_pld[wr_ptr]  <= slot_pld[RD_LAT-1];
        end
    end

    // Pointers wrap naturally since RSP_DEPTH is a power of two.
    always_ff @(posedge clk_2g or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            rd_outstanding <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            case ({acc_rd, push})
                2'b10:   rd_outstanding <= rd_outstanding + 1'b1;
                2'b01:   rd_outstanding <= rd_outstanding - 1'b1;
                default: rd_outstanding <= rd_outstanding;
            endcase
`ifdef MEM_CHAIN_INIT_CHECK_EN
            if (push && full && !pop)
                $error("mem_chain_initiator: response FIFO overflow");
`endif
        end
    end

`ifndef MEM_CHAIN_INIT_CHECK_EN
    logic unused_full;
    assign unused_full = full;
`endif

endmodule

// File: tb/tb_mem_chain_initiator.sv
// Randomized bench for mem_chain_initiator with a cycle-indexed reference model and a
// response scoreboard; honours MEM_CHAIN_INIT_CHECK_EN when it is defined for the build.
module tb_mem_chain_initiator;
    import mem_chain_pkg::*;

    localparam int RD_LAT      = 8;
    localparam int WR_DATA_OFS = 2;
    localparam int RSP_DEPTH   = 8;
    localparam int W           = 60;
`ifdef MEM_CHAIN_INIT_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic         clk_2g = 1'b0;
    logic         rst_n = 1'b1;
    logic         req_vld = 1'b0;
    logic         req_rdy;
    logic         req_is_wr = 1'b0;
    arb_out_req_t req_pld = '0;
    logic [31:0]  req_wdata = '0;
    logic         read_cmd_vld_out, write_cmd_vld_out, wr_data_out_vld;
    arb_out_req_t read_cmd_pld_out, write_cmd_pld_out, rsp_pld;
    logic [31:0]  wr_data_out, rsp_data;
    logic         rd_data_in_vld = 1'b0;
    logic [31:0]  rd_data_in = '0;
    logic         rsp_vld;
    logic         rsp_rdy = 1'b0;
    logic [4:0]   rd_outstanding;
    logic         err_lost, err_spurious;

    mem_chain_initiator #(.RD_LAT(RD_LAT), .WR_DATA_OFS(WR_DATA_OFS), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk_2g(clk_2g), .rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_is_wr(req_is_wr),
        .req_pld(req_pld), .req_wdata(req_wdata),
        .read_cmd_vld_out(read_cmd_vld_out), .read_cmd_pld_out(read_cmd_pld_out),
        .write_cmd_vld_out(write_cmd_vld_out), .write_cmd_pld_out(write_cmd_pld_out),
        .wr_data_out_vld(wr_data_out_vld), .wr_data_out(wr_data_out),
        .rd_data_in_vld(rd_data_in_vld), .rd_data_in(rd_data_in),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_pld(rsp_pld),
        .rd_outstanding(rd_outstanding), .err_lost(err_lost), .err_spurious(err_spurious)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk_2g = ~clk_2g;
    int cyc = 0;
    always @(posedge clk_2g) cyc <= cyc + 1;

    // ---------------- reference model state ----------------
    int checks = 0, failures = 0;
    logic [W-1:0] exp_q[$];          // {pld, data} of each expected response
    int           exp_t[$];          // first cycle that response is visible
    arb_out_req_t exp_rcmd[int];
    arb_out_req_t exp_wcmd[int];
    logic [31:0]  exp_wdat[int];
    arb_out_req_t rd_slot[int];      // return cycle -> payload of the read expected there
    logic [31:0]  ret_plan[int];     // chain model: cycle -> data the tail returns
    int           rd_s_q[$];
    int  n_rd_acc = 0, n_popped = 0, pop_base = 0, dut_acc = 0;
    bit  exp_rdy = 1'b1;
    int  lost_from = -1, spur_from = -1;
    bit  mon_en = 1'b0, assert_now = 1'b0, release_now = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    function automatic arb_out_req_t rand_pld();
        logic [31:0] r;
        r = $urandom;
        return r[27:0];
    endfunction

    function automatic logic [31:0] capture(input bit v, input logic [31:0] d);
        if (CHECK && !v) return 32'h0;
        return d;
    endfunction

    // ---------------- driver: one clock cycle of stimulus ----------------
    task automatic step(input bit rv, input bit wr, input arb_out_req_t pld, input logic [31:0] wd,
                        input bit rr, input bit lose, input bit spur, input logic [31:0] rdata);
        bit          ret_v;
        logic [31:0] ret_d;
        int          c, s;
        @(posedge clk_2g);
        #1;
        c = cyc;
        if (release_now) begin
            rst_n = 1'b1;
            release_now = 1'b0;
        end
        if (assert_now) begin
            rst_n = 1'b0;
            assert_now = 1'b0;
            exp_q.delete(); exp_t.delete(); exp_rcmd.delete(); exp_wcmd.delete();
            exp_wdat.delete(); rd_slot.delete(); rd_s_q.delete();
            n_rd_acc = 0; pop_base = n_popped; lost_from = -1; spur_from = -1;
        end
        if (ret_plan.exists(c)) begin
            ret_v = 1'b1;
            ret_d = ret_plan[c];
            ret_plan.delete(c);
        end else begin
            ret_v = spur;
            ret_d = $urandom;
        end
        rd_data_in_vld = ret_v;
        rd_data_in     = ret_d;
        if (rst_n) begin
            if (rd_slot.exists(c)) begin
                exp_q.push_back({rd_slot[c], capture(ret_v, ret_d)});
                exp_t.push_back(c + 1);
                if (CHECK && !ret_v && lost_from < 0) lost_from = c + 1;
                rd_slot.delete(c);
            end else if (CHECK && ret_v && spur_from < 0) begin
                spur_from = c + 1;
            end
        end
        exp_rdy   = (n_rd_acc - (n_popped - pop_base)) < RSP_DEPTH;
        req_vld   = rv;
        req_is_wr = wr;
        req_pld   = pld;
        req_wdata = wd;
        rsp_rdy   = rr;
        if (rst_n && rv && exp_rdy) begin
            if (wr) begin
                exp_wcmd[c+1] = pld;
                exp_wdat[c+1+WR_DATA_OFS] = wd;
            end else begin
                n_rd_acc++;
                s = c + 1 + RD_LAT;
                exp_rcmd[c+1] = pld;
                rd_slot[s] = pld;
                rd_s_q.push_back(s);
                if (!lose) ret_plan[s] = rdata;
            end
        end
    endtask

    task automatic idle(input int n, input bit rr);
        repeat (n) step(1'b0, 1'b0, '0, '0, rr, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset(input int n);
        assert_now = 1'b1;
        idle(n, 1'b1);
        release_now = 1'b1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk_2g) begin
        int           c, outs;
        bit           ev;
        arb_out_req_t ep;
        logic [31:0]  ed;
        logic [W-1:0] h;
        if (mon_en) begin
            c = cyc;
            if (rst_n && req_vld && req_rdy) dut_acc++;
            chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
            ev = exp_rcmd.exists(c);
            ep = ev ? exp_rcmd[c] : '0;
            chk("read_cmd_vld", 64'(read_cmd_vld_out), 64'(ev));
            chk("read_cmd_pld", 64'(read_cmd_pld_out), 64'(ep));
            ev = exp_wcmd.exists(c);
            ep = ev ? exp_wcmd[c] : '0;
            chk("write_cmd_vld", 64'(write_cmd_vld_out), 64'(ev));
            chk("write_cmd_pld", 64'(write_cmd_pld_out), 64'(ep));
            ev = exp_wdat.exists(c);
            ed = ev ? exp_wdat[c] : '0;
            chk("wr_data_vld", 64'(wr_data_out_vld), 64'(ev));
            chk("wr_data", 64'(wr_data_out), 64'(ed));
            while (rd_s_q.size() > 0 && rd_s_q[0] < c) void'(rd_s_q.pop_front());
            outs = 0;
            foreach (rd_s_q[i]) if (rd_s_q[i] - RD_LAT - 1 < c && rd_s_q[i] >= c) outs++;
            chk("rd_outstanding", 64'(rd_outstanding), 64'(outs));
            chk("err_lost", 64'(err_lost), 64'(lost_from >= 0 && c >= lost_from));
            chk("err_spurious", 64'(err_spurious), 64'(spur_from >= 0 && c >= spur_from));
            ev = exp_q.size() > 0 && exp_t[0] <= c;
            h  = ev ? exp_q[0] : '0;
            chk("rsp_vld", 64'(rsp_vld), 64'(ev));
            chk("rsp_data", 64'(rsp_data), 64'(h[31:0]));
            chk("rsp_pld", 64'(rsp_pld), 64'(h[W-1:32]));
            if (ev && rsp_rdy) begin
                void'(exp_q.pop_front());
                void'(exp_t.pop_front());
                n_popped++;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int a0;
        #2;
        rst_n  = 1'b0;
        mon_en = 1'b1;
        idle(3, 1'b1);
        release_now = 1'b1;
        idle(2, 1'b1);

        // single read with a known return value
        step(1'b1, 1'b0, 28'h1_2345_67, '0, 1'b1, 1'b0, 1'b0, 32'hA5A5_0001);
        idle(12, 1'b1);
        // single write
        step(1'b1, 1'b1, 28'h7_0BEE_F0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, '0);
        idle(5, 1'b1);

        // credit exhaustion: ten back-to-back reads with no response pops
        a0 = dut_acc;
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b0, rand_pld(), '0, 1'b0, 1'b0, 1'b0, $urandom);
        chk("burst_accepts", 64'(dut_acc - a0), 64'(8));
        idle(12, 1'b0);
        idle(12, 1'b1);

        // lost return, then a stray return with nothing outstanding
        step(1'b1, 1'b0, rand_pld(), '0, 1'b1, 1'b1, 1'b0, '0);
        idle(12, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, '0);
        idle(4, 1'b1);

        // reset with three reads in flight; their returns arrive after release
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, rand_pld(), '0, 1'b1, 1'b0, 1'b0, $urandom);
        idle(2, 1'b1);
        do_reset(2);
        idle(14, 1'b1);

        // randomized traffic, with one reset in the middle
        for (int i = 0; i < 900; i++) begin
            if (i == 450) do_reset(1 + $urandom_range(0, 2));
            step($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 40, rand_pld(), $urandom,
                 $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 3, $urandom);
        end
        idle(30, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
